// File: rtl/l2_dv_pkg.sv
// Shared types and sizing for the L2 dirty/valid SRAM access controller.
package l2_dv_pkg;

    localparam int SETS   = 128;
    localparam int WAYS   = 8;
    localparam int SET_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int DV_W   = 2;
    localparam int ADDR_W = SET_W + WAY_W;
    localparam int ROW_W  = WAYS * DV_W;

    typedef logic [DV_W-1:0] dv_t;

    localparam int DV_VALID_BIT = 0;
    localparam int DV_DIRTY_BIT = 1;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        RD_WAIT,
        RSP
    } state_t;

endpackage

// File: rtl/l2_dv_init_seq.sv
// Post-reset clear sweep: walks every {set, way} address once, writing zero.
module l2_dv_init_seq
    import l2_dv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(SETS * WAYS - 1);

    logic              run;
    logic              finished;
    logic [ADDR_W-1:0] cnt;

    // run starts on the first edge after reset release so sram_we stays low in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            finished <= 1'b0;
            cnt      <= '0;
        end else if (!finished) begin
            if (!run) begin
                run <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == ADDR_MAX) begin
                    run      <= 1'b0;
                    finished <= 1'b1;
                end
            end
        end
    end

    assign we   = run;
    assign addr = cnt;
    assign done = run && (cnt == ADDR_MAX);

endmodule

// File: rtl/l2_dv_ctrl.sv
// L2 dirty/valid SRAM access controller: clear sweep, write-priority arbitration, registered set response.
// Define L2_DV_INIT_EN to enable the post-reset clear sweep; otherwise the SRAM is assumed pre-cleared.
module l2_dv_ctrl
    import l2_dv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [SET_W-1:0]  rd_set,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ROW_W-1:0]  rsp_dv,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [SET_W-1:0]  wr_set,
    input  logic [WAY_W-1:0]  wr_way,
    input  dv_t               wr_dv,
    output logic              init_done,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output dv_t               sram_din,
    input  logic [ROW_W-1:0]  sram_dout
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic              init_last;
    logic              init_set;
    logic              rd_fire;
    logic              wr_fire;

`ifdef L2_DV_INIT_EN
    localparam state_t RESET_STATE = INIT;

    l2_dv_init_seq u_init_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (init_we),
        .addr  (init_addr),
        .done  (init_last)
    );

    assign init_set = init_last;
`else
    localparam state_t RESET_STATE = IDLE;

    assign init_we   = 1'b0;
    assign init_addr = '0;
    assign init_last = 1'b0;
    assign init_set  = 1'b1;
`endif

    // Readiness is gated by init_done so both builds present zero readies during reset
    assign wr_ready  = init_done;
    assign rd_ready  = init_done && (state == IDLE) && !wr_valid;
    assign wr_fire   = wr_valid && wr_ready;
    assign rd_fire   = rd_valid && rd_ready;
    assign rsp_valid = (state == RSP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_STATE;
            init_done <= 1'b0;
            addr_q    <= '0;
            rsp_dv    <= '0;
        end else begin
            state     <= state_nxt;
            init_done <= init_done | init_set;
            addr_q    <= sram_addr;
            if (state == RD_WAIT) begin
                rsp_dv <= sram_dout;
            end
        end
    end

    // A write can land in any post-init state and overrides the port, so it is applied last
    always_comb begin
        state_nxt = state;
        sram_we   = 1'b0;
        sram_addr = addr_q;
        sram_din  = '0;
        case (state)
            INIT: begin
                sram_we = init_we;
                if (init_we) begin
                    sram_addr = init_addr;
                end
                if (init_last) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (rd_fire) begin
                    sram_addr = {rd_set, {WAY_W{1'b0}}};
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                state_nxt = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = RESET_STATE;
            end
        endcase
        if (wr_fire) begin
            sram_we   = 1'b1;
            sram_addr = {wr_set, wr_way};
            sram_din  = wr_dv;
        end
    end

endmodule

// File: tb/tb_l2_dv_ctrl.sv
// Directed and randomised checks of l2_dv_ctrl against a behavioural SRAM and a dv reference array.
module tb_l2_dv_ctrl;
    import l2_dv_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rd_valid = 1'b0;
    logic              rd_ready;
    logic [SET_W-1:0]  rd_set = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [ROW_W-1:0]  rsp_dv;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [SET_W-1:0]  wr_set = '0;
    logic [WAY_W-1:0]  wr_way = '0;
    dv_t               wr_dv = '0;
    logic              init_done;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    dv_t               sram_din;
    logic [ROW_W-1:0]  sram_dout;

    int total = 0;
    int bad   = 0;

    logic             fill_en = 1'b1;
    logic [ROW_W-1:0] mem     [SETS];
    logic [ROW_W-1:0] ref_mem [SETS];

`ifdef L2_DV_INIT_EN
    localparam logic [ROW_W-1:0] FILL = 16'hFFFF;
`else
    localparam logic [ROW_W-1:0] FILL = 16'h0000;
`endif

    l2_dv_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_set    (rd_set),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dv    (rsp_dv),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_set    (wr_set),
        .wr_way    (wr_way),
        .wr_dv     (wr_dv),
        .init_done (init_done),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    always #5 clk = ~clk;

    // Single-port SRAM: write on we, otherwise registered read of the addressed set row
    always @(posedge clk) begin
        if (fill_en) begin
            for (int r = 0; r < SETS; r++) mem[r] <= FILL;
            sram_dout <= '0;
        end else if (sram_we) begin
            mem[sram_addr[ADDR_W-1:WAY_W]][sram_addr[WAY_W-1:0]*DV_W +: DV_W] <= sram_din;
        end else begin
            sram_dout <= mem[sram_addr[ADDR_W-1:WAY_W]];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [SET_W-1:0] rs, input logic wv,
                                 input logic [SET_W-1:0] ws, input logic [WAY_W-1:0] ww, input dv_t wd);
        rd_valid = rv;
        rd_set   = rs;
        wr_valid = wv;
        wr_set   = ws;
        wr_way   = ww;
        wr_dv    = wd;
    endtask

    task automatic do_write(input logic [SET_W-1:0] s, input logic [WAY_W-1:0] w, input dv_t d);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b1, s, w, d);
        #1;
        checkOutput("wr_accept", 32'({wr_ready, sram_we, sram_addr, sram_din}), 32'({1'b1, 1'b1, s, w, d}));
        @(posedge clk);
        #1 applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
        ref_mem[s][w*DV_W +: DV_W] = d;
    endtask

    task automatic do_read(input logic [SET_W-1:0] s, input logic [ROW_W-1:0] exp);
        @(negedge clk);
        applyStimulus(1'b1, s, 1'b0, '0, '0, '0);
        #1;
        checkOutput("rd_issue", 32'({rd_ready, sram_we, sram_addr}), 32'({1'b1, 1'b0, s, 3'b000}));
        @(posedge clk);
        #1 applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checkOutput("rd_wait", 32'({rsp_valid, rd_ready}), 32'(2'b00));
        @(negedge clk);
        checkOutput("rsp", 32'({rsp_valid, rsp_dv}), 32'({1'b1, exp}));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < SETS; r++) ref_mem[r] = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_ctl", 32'({rd_ready, wr_ready, rsp_valid, init_done, sram_we}), 32'(0));
        checkOutput("reset_rsp_dv", 32'(rsp_dv), 32'(0));
        checkOutput("reset_sram", 32'({sram_addr, sram_din}), 32'(0));
        fill_en = 1'b0;

`ifdef L2_DV_INIT_EN
        // Abort the sweep at address 400 and check it restarts from zero
        @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        @(negedge clk);
        checkOutput("sweep_400", 32'({sram_we, sram_addr}), 32'({1'b1, 10'd400}));
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_ctl", 32'({rd_ready, wr_ready, rsp_valid, init_done, sram_we}), 32'(0));
        checkOutput("midreset_sram", 32'({sram_addr, sram_din}), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 7'h2A, 1'b1, 7'h55, 3'd5, 2'b11);
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            checkOutput("init_sweep", 32'({init_done, rd_ready, wr_ready, sram_we, sram_addr, sram_din}),
                        32'({4'b0001, 10'(i), 2'b00}));
            if (i == 1023) applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
        end
        @(negedge clk);
        checkOutput("init_done", 32'({init_done, wr_ready, rd_ready, sram_we, sram_addr}),
                    32'({4'b1110, 10'd1023}));
        do_read(7'd0, 16'h0000);
        do_read(7'd127, 16'h0000);
`else
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("init_done", 32'({init_done, wr_ready, rd_ready, sram_we}), 32'(4'b1110));
`endif

        // Write then read the same set: write-first across cycles
        do_write(7'd5, 3'd3, 2'b11);
        do_read(7'd5, 16'h00C0);
        do_read(7'd4, 16'h0000);
        do_read(7'd6, 16'h0000);
        do_write(7'd127, 3'd7, 2'b10);
        do_read(7'd127, 16'h8000);
        do_write(7'd0, 3'd0, 2'b01);
        do_read(7'd0, 16'h0001);

        // Simultaneous read and write: write wins, read goes next cycle
        @(negedge clk);
        applyStimulus(1'b1, 7'd9, 1'b1, 7'd9, 3'd1, 2'b01);
        #1;
        checkOutput("both_wr", 32'({rd_ready, wr_ready, sram_we, sram_addr, sram_din}),
                    32'({3'b011, 7'd9, 3'd1, 2'b01}));
        @(posedge clk);
        #1 applyStimulus(1'b1, 7'd9, 1'b0, '0, '0, '0);
        ref_mem[9][3:2] = 2'b01;
        @(negedge clk);
        checkOutput("both_rd", 32'({rd_ready, sram_we, sram_addr}), 32'({2'b10, 7'd9, 3'd0}));
        @(posedge clk);
        #1 applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("both_rsp", 32'({rsp_valid, rsp_dv}), 32'({1'b1, 16'h0004}));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;

        // Stalled response stays stable while the same set is updated underneath it
        @(negedge clk);
        applyStimulus(1'b1, 7'd5, 1'b0, '0, '0, '0);
        @(posedge clk);
        #1 applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("rsp_hold", 32'({rsp_valid, rd_ready, rsp_dv}), 32'({2'b10, 16'h00C0}));
            if (i == 2) applyStimulus(1'b0, '0, 1'b1, 7'd5, 3'd0, 2'b01);
            if (i == 3) applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
        end
        ref_mem[5][1:0] = 2'b01;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        do_read(7'd5, 16'h00C1);

        for (int n = 0; n < 10000; n++) begin
            logic [SET_W-1:0] s;
            s = 7'($urandom_range(0, SETS - 1));
            if ($urandom_range(0, 1) == 1)
                do_write(s, 3'($urandom_range(0, WAYS - 1)), 2'($urandom_range(0, 3)));
            else
                do_read(s, ref_mem[s]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
